// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad receive path.
// Frame bit index is col*NUM_ROWS+row; key codes are {row[1:0], col[1:0]}.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef logic [3:0]                   key_code_t;
    typedef logic [NUM_ROWS*NUM_COLS-1:0] key_frame_t;

    typedef enum logic [1:0] {IDLE, PRESSED, MULTI} kp_state_t;

    // Lowest set bit wins; callers only use this on single-bit frames.
    function automatic key_code_t onehot_to_code(key_frame_t frame);
        key_code_t  code;
        logic [3:0] idx;
        code = '0;
        for (int i = NUM_ROWS*NUM_COLS-1; i >= 0; i--) begin
            idx = 4'(i);
            if (frame[i]) code = {idx[1:0], idx[3:2]};
        end
        return code;
    endfunction

    function automatic key_frame_t code_to_onehot(key_code_t code);
        return key_frame_t'(1) << {code[1:0], code[3:2]};
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous row lines, with column_index
// delayed by the same two stages so each row sample stays tagged with its column.
module keypad_row_sync (
    input  logic       slow_clk,
    input  logic       rst,
    input  logic [1:0] column_index,
    input  logic [3:0] row_in,
    output logic [3:0] row_s2,
    output logic [1:0] col_d2
);

    logic [3:0] row_s1;
    logic [1:0] col_d1;

    // NOTE: non-blocking assignments so every stage samples the previous value of its predecessor.
    always_ff @(posedge slow_clk) begin
        if (!rst) begin
            row_s1 <= '0;
            row_s2 <= '0;
            col_d1 <= '0;
            col_d2 <= '0;
        end else begin
            row_s1 <= row_in;
            row_s2 <= row_s1;
            col_d1 <= column_index;
            col_d2 <= col_d1;
        end
    end

endmodule

// File: rtl/keypad_row_decoder.sv
// Builds 16-bit key frames from the scanned rows, debounces whole frames and
// reports clean single-key presses; multi-key frames are flagged and ignored.
module keypad_row_decoder
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       slow_clk,
    input  logic       rst,
    input  logic [1:0] column_index,
    input  logic [3:0] row_in,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pressed,
    output logic       multi_key
);

    localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_FRAMES - 1);

    logic [3:0] row_s2;
    logic [1:0] col_d2;
    key_frame_t frame_acc, frame_acc_next, frame_new, frame_prev;
    logic       frame_done;
    logic [3:0] stable_cnt, stable_cnt_next;
    logic       stable, frame_zero, frame_single;
    kp_state_t  state;

    keypad_row_sync u_sync (
        .slow_clk     (slow_clk),
        .rst          (rst),
        .column_index (column_index),
        .row_in       (row_in),
        .row_s2       (row_s2),
        .col_d2       (col_d2)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        frame_acc_next = frame_acc;
        frame_acc_next[{col_d2, 2'b00} +: 4] = row_s2;

        stable_cnt_next = '0;
        if (frame_new == frame_prev)
            stable_cnt_next = (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + 4'd1;
        stable = frame_done && (stable_cnt_next == CNT_MAX);

        frame_zero   = (frame_new == '0);
        frame_single = !frame_zero && ((frame_new & (frame_new - key_frame_t'(1))) == '0);
    end

    always_ff @(posedge slow_clk) begin
        if (!rst) begin
            frame_acc  <= '0;
            frame_new  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_acc  <= frame_acc_next;
            frame_done <= (col_d2 == 2'd3);
            if (col_d2 == 2'd3) frame_new <= frame_acc_next;
        end
    end

    // Saturating run length of identical frames; a single bounce restarts it.
    always_ff @(posedge slow_clk) begin
        if (!rst) begin
            frame_prev <= '0;
            stable_cnt <= '0;
        end else if (frame_done) begin
            frame_prev <= frame_new;
            stable_cnt <= stable_cnt_next;
        end
    end

    always_ff @(posedge slow_clk) begin
        if (!rst) begin
            state       <= IDLE;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_pressed <= 1'b0;
            multi_key   <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (stable) begin
                unique case (state)
                    IDLE: begin
                        if (frame_single) begin
                            state       <= PRESSED;
                            key_code    <= onehot_to_code(frame_new);
                            key_valid   <= 1'b1;
                            key_pressed <= 1'b1;
                        end else if (!frame_zero) begin
                            state     <= MULTI;
                            multi_key <= 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (frame_zero) begin
                            state       <= IDLE;
                            key_pressed <= 1'b0;
                        end else if (frame_new != code_to_onehot(key_code)) begin
                            state       <= MULTI;
                            key_pressed <= 1'b0;
                            multi_key   <= 1'b1;
                        end
                    end
                    MULTI: begin
                        if (frame_zero) begin
                            state     <= IDLE;
                            multi_key <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_row_decoder.sv
// Self-checking bench for keypad_row_decoder: directed vector table, hand-written
// bounce/reset sequences and randomized key activity against a frame-history model.
module tb_keypad_row_decoder;

    localparam int D      = 4;
    localparam int WINDOW = 4 * (D + 2);

    logic       slow_clk = 1'b0;
    logic       rst;
    logic [1:0] column_index;
    logic [3:0] row_in;
    logic [3:0] key_code;
    logic       key_valid, key_pressed, multi_key;

    logic [15:0] keys;   // pressed keys, bit col*4+row
    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    always #5 slow_clk = ~slow_clk;
    assign row_in = keys[{column_index, 2'b00} +: 4];

    keypad_row_decoder #(.DEBOUNCE_FRAMES(D)) dut (
        .slow_clk     (slow_clk),
        .rst          (rst),
        .column_index (column_index),
        .row_in       (row_in),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .key_pressed  (key_pressed),
        .multi_key    (multi_key)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: samples reach the frame two edges late; a frame is acted on
    // only when the last D completed frames (reset seeds one all-zero frame) agree.
    localparam int M_IDLE = 0, M_HELD = 1, M_MULTI = 2;
    logic [1:0]  m_col_q[$];
    logic [3:0]  m_row_q[$];
    logic [15:0] m_hist[$];
    logic [15:0] m_acc, m_pend_frame, m_held;
    logic        m_pend;
    int          m_state;
    logic [3:0]  m_code;
    logic        m_valid, m_pressed, m_multi;

    task automatic model_reset();
        m_col_q = '{2'd0, 2'd0};
        m_row_q = '{4'd0, 4'd0};
        m_hist  = '{16'd0};
        m_acc = '0; m_pend = 1'b0; m_pend_frame = '0; m_held = '0;
        m_state = M_IDLE;
        m_code = '0; m_valid = 1'b0; m_pressed = 1'b0; m_multi = 1'b0;
    endtask

    task automatic model_apply(input logic [15:0] f);
        int n, pos;
        n = $countones(f);
        pos = 0;
        for (int i = 15; i >= 0; i--) if (f[i]) pos = i;
        case (m_state)
            M_IDLE: begin
                if (n == 1) begin
                    m_state = M_HELD; m_held = f;
                    m_code = 4'((pos % 4) * 4 + pos / 4);
                    m_valid = 1'b1; m_pressed = 1'b1;
                end else if (n > 1) begin
                    m_state = M_MULTI; m_multi = 1'b1;
                end
            end
            M_HELD: begin
                if (n == 0) begin
                    m_state = M_IDLE; m_pressed = 1'b0;
                end else if (f != m_held) begin
                    m_state = M_MULTI; m_pressed = 1'b0; m_multi = 1'b1;
                end
            end
            default: begin
                if (n == 0) begin
                    m_state = M_IDLE; m_multi = 1'b0;
                end
            end
        endcase
    endtask

    task automatic model_step(input logic r, input logic [1:0] c, input logic [3:0] rows);
        logic       settled;
        logic [1:0] sc;
        logic [3:0] sr;
        if (!r) begin
            model_reset();
            return;
        end
        m_valid = 1'b0;
        if (m_pend) begin
            m_hist.push_back(m_pend_frame);
            if (m_hist.size() > D) void'(m_hist.pop_front());
            settled = (m_hist.size() == D);
            foreach (m_hist[i]) if (m_hist[i] != m_pend_frame) settled = 1'b0;
            if (settled) model_apply(m_pend_frame);
        end
        sc = m_col_q.pop_front();
        sr = m_row_q.pop_front();
        m_acc[{sc, 2'b00} +: 4] = sr;
        m_pend = (sc == 2'd3);
        m_pend_frame = m_acc;
        m_col_q.push_back(c);
        m_row_q.push_back(rows);
    endtask

    // One slow_clk cycle: outputs compared #1 after the edge, then the scanner advances.
    task automatic tick();
        logic       r;
        logic [1:0] c;
        logic [3:0] rw;
        r = rst; c = column_index; rw = keys[{column_index, 2'b00} +: 4];
        @(posedge slow_clk);
        #1;
        model_step(r, c, rw);
        check("model", {key_code, key_valid, key_pressed, multi_key},
              {m_code, m_valid, m_pressed, m_multi});
        check("exclusive", 32'((key_valid | key_pressed) & multi_key), 32'd0);
        if (key_valid) pulse_cnt++;
        column_index = column_index + 2'd1;
    endtask

    typedef struct {
        string       name;
        logic [15:0] keys;
        logic [3:0]  code;
        logic        pressed;
        logic        multi;
        int          pulses;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int p0, last_bad, first;

        vecs[0] = '{"idle",         16'h0000, 4'h0, 1'b0, 1'b0, 0};
        vecs[1] = '{"press_r2c1",   16'h0040, 4'h9, 1'b1, 1'b0, 1};
        vecs[2] = '{"release_r2c1", 16'h0000, 4'h9, 1'b0, 1'b0, 0};
        vecs[3] = '{"dual_r0c0_r3c3", 16'h8001, 4'h9, 1'b0, 1'b1, 0};
        vecs[4] = '{"release_dual", 16'h0000, 4'h9, 1'b0, 1'b0, 0};
        vecs[5] = '{"press_r1c2",   16'h0200, 4'h6, 1'b1, 1'b0, 1};
        vecs[6] = '{"add_r1c0",     16'h0202, 4'h6, 1'b0, 1'b1, 0};
        vecs[7] = '{"release_all",  16'h0000, 4'h6, 1'b0, 1'b0, 0};
        vecs[8] = '{"press_r1c0",   16'h0002, 4'h4, 1'b1, 1'b0, 1};
        vecs[9] = '{"release_r1c0", 16'h0000, 4'h4, 1'b0, 1'b0, 0};

        model_reset();
        column_index = 2'd0;
        keys = 16'h0040;
        rst  = 1'b0;

        // Reset held with a key down: every output stays low.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_outputs", {key_code, key_valid, key_pressed, multi_key}, 32'd0);
        end
        keys = 16'h0000;
        rst  = 1'b1;

        foreach (vecs[v]) begin
            keys = vecs[v].keys;
            p0 = pulse_cnt;
            last_bad = 0;
            for (int i = 1; i <= 40; i++) begin
                tick();
                if ({key_pressed, multi_key} != {vecs[v].pressed, vecs[v].multi}) last_bad = i;
            end
            check({vecs[v].name, "_code"},   key_code, vecs[v].code);
            check({vecs[v].name, "_levels"}, {key_pressed, multi_key}, {vecs[v].pressed, vecs[v].multi});
            check({vecs[v].name, "_pulses"}, pulse_cnt - p0, vecs[v].pulses);
            check({vecs[v].name, "_latency_ok"}, 32'(last_bad < WINDOW), 32'd1);
        end

        // Bouncing r0c3 every 2 frames for 12 frames, then held.
        p0 = pulse_cnt;
        for (int t = 0; t < 6; t++) begin
            keys = (t % 2 == 0) ? 16'h1000 : 16'h0000;
            repeat (8) tick();
        end
        check("bounce_no_pulse", pulse_cnt - p0, 32'd0);
        keys = 16'h1000;
        p0 = pulse_cnt;
        first = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (key_valid && first < 0) first = i;
        end
        check("bounce_pulses", pulse_cnt - p0, 32'd1);
        check("bounce_code", key_code, 32'h3);
        check("bounce_latency_ok", 32'(first >= 1 && first <= WINDOW), 32'd1);

        // Reset while a key is accepted, key still held afterwards.
        keys = 16'h0000;
        repeat (40) tick();
        keys = 16'h0040;
        repeat (40) tick();
        check("pre_reset_pressed", key_pressed, 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("mid_reset_outputs", {key_code, key_valid, key_pressed, multi_key}, 32'd0);
        p0 = pulse_cnt;
        repeat (40) tick();
        check("post_reset_pulses", pulse_cnt - p0, 32'd1);
        check("post_reset_code", key_code, 32'h9);
        check("post_reset_pressed", key_pressed, 32'd1);

        // Randomized key activity, checked cycle by cycle against the model.
        for (int s = 0; s < 80; s++) begin
            int sel, hold;
            sel  = $urandom_range(0, 9);
            hold = $urandom_range(1, 60);
            if (sel < 4)      keys = 16'h0000;
            else if (sel < 8) keys = 16'h0001 << $urandom_range(0, 15);
            else              keys = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            for (int i = 0; i < hold; i++) begin
                rst = ($urandom_range(0, 299) != 0);
                tick();
            end
            rst = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
